// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Center-aligned mode is compiled in only when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

    localparam int ADDR_PERIOD     = 0;
    localparam int ADDR_PRESCALE   = 1;
    localparam int ADDR_CTRL       = 2;
    localparam int ADDR_DUTY0      = 3;
    localparam int CTRL_CENTER_BIT = 0;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Write-only register bus for the PWM generator: one write per cycle, no backpressure.
interface pwm_multi_channel_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaled shared timebase: prescaler, up/up-down counter, boundary detect and period_tick.
// The up-down (center) counting path exists only when PWM_CENTER_ALIGN_EN is defined.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] prescale,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic             center,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             boundary,
    output logic             period_tick
);

    logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             period_tick_q, period_tick_d;
`ifdef PWM_CENTER_ALIGN_EN
    dir_t             dir_q, dir_d;
`endif

    assign tick = en && (pre_cnt_q >= prescale);

    // boundary flags the last count position of a period; the period ends on the next tick.
`ifdef PWM_CENTER_ALIGN_EN
    assign boundary = center ? ((period == '0) || ((dir_q == DIR_DOWN) && (cnt_q == '0)))
                             : (cnt_q >= period);
`else
    assign boundary = (cnt_q >= period);
`endif

    always_comb begin
        pre_cnt_d     = pre_cnt_q;
        cnt_d         = cnt_q;
        period_tick_d = tick && boundary;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d         = dir_q;
`endif
        if (!en) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d     = DIR_UP;
`endif
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            if (tick) begin
                if (boundary) begin
                    cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
                    dir_d = DIR_UP;
`endif
                end else begin
`ifdef PWM_CENTER_ALIGN_EN
                    // At the top in center mode the count holds one tick while turning round.
                    if (center && (dir_q == DIR_UP) && (cnt_q >= period)) begin
                        dir_d = DIR_DOWN;
                    end else if (center && (dir_q == DIR_DOWN)) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            period_tick_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q         <= DIR_UP;
`endif
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            period_tick_q <= period_tick_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q         <= dir_d;
`endif
        end
    end

    assign cnt         = cnt_q;
    assign period_tick = period_tick_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: double-buffered register file, shared timebase, per-channel comparators.
// Defining PWM_CENTER_ALIGN_EN adds the control register and center-aligned counting.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = $clog2(CHANNELS + 3)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    pwm_multi_channel_if.slave   bus,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 period_tick,
    output logic [WIDTH-1:0]     cnt
);

    logic [WIDTH-1:0]                period_sh_q, period_sh_d;
    logic [WIDTH-1:0]                period_act_q, period_act_d;
    logic [WIDTH-1:0]                prescale_sh_q, prescale_sh_d;
    logic [WIDTH-1:0]                prescale_act_q, prescale_act_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_act_q, duty_act_d;
    logic [CHANNELS-1:0]             pwm_out_q, pwm_out_d;
`ifdef PWM_CENTER_ALIGN_EN
    logic                            center_sh_q, center_sh_d;
    logic                            center_act_q, center_act_d;
`endif

    logic tick;
    logic boundary;
    logic copy_en;

    pwm_timebase #(
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period      (period_act_q),
        .prescale    (prescale_act_q),
`ifdef PWM_CENTER_ALIGN_EN
        .center      (center_act_q),
`endif
        .cnt         (cnt),
        .tick        (tick),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    // Shadow writes; out-of-range addresses simply match nothing.
    always_comb begin
        period_sh_d   = period_sh_q;
        prescale_sh_d = prescale_sh_q;
        duty_sh_d     = duty_sh_q;
`ifdef PWM_CENTER_ALIGN_EN
        center_sh_d   = center_sh_q;
`endif
        if (bus.wr_en) begin
            if (bus.wr_addr == ADDR_W'(ADDR_PERIOD)) begin
                period_sh_d = bus.wr_data;
            end
            if (bus.wr_addr == ADDR_W'(ADDR_PRESCALE)) begin
                prescale_sh_d = bus.wr_data;
            end
`ifdef PWM_CENTER_ALIGN_EN
            if (bus.wr_addr == ADDR_W'(ADDR_CTRL)) begin
                center_sh_d = bus.wr_data[CTRL_CENTER_BIT];
            end
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.wr_addr == ADDR_W'(ADDR_DUTY0 + i)) begin
                    duty_sh_d[i] = bus.wr_data;
                end
            end
        end
    end

    // The copy reads the registered shadow, so a write landing on the boundary edge waits a period.
    assign copy_en = !en || (tick && boundary);

    always_comb begin
        period_act_d   = period_act_q;
        prescale_act_d = prescale_act_q;
        duty_act_d     = duty_act_q;
`ifdef PWM_CENTER_ALIGN_EN
        center_act_d   = center_act_q;
`endif
        if (copy_en) begin
            period_act_d   = period_sh_q;
            prescale_act_d = prescale_sh_q;
            duty_act_d     = duty_sh_q;
`ifdef PWM_CENTER_ALIGN_EN
            center_act_d   = center_sh_q;
`endif
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
        assign pwm_out_d[i] = en && (cnt < duty_act_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh_q    <= '1;
            period_act_q   <= '1;
            prescale_sh_q  <= '0;
            prescale_act_q <= '0;
            duty_sh_q      <= '0;
            duty_act_q     <= '0;
            pwm_out_q      <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            center_sh_q    <= 1'b0;
            center_act_q   <= 1'b0;
`endif
        end else begin
            period_sh_q    <= period_sh_d;
            period_act_q   <= period_act_d;
            prescale_sh_q  <= prescale_sh_d;
            prescale_act_q <= prescale_act_d;
            duty_sh_q      <= duty_sh_d;
            duty_act_q     <= duty_act_d;
            pwm_out_q      <= pwm_out_d;
`ifdef PWM_CENTER_ALIGN_EN
            center_sh_q    <= center_sh_d;
            center_act_q   <= center_act_d;
`endif
        end
    end

    assign pwm_out = pwm_out_q;

endmodule
